// File: rtl/ahb_slave_interface.sv
// AHB-Lite responder: decodes and checks each transfer, adds wait states,
// and issues one backend request per good transfer.
module ahb_slave_interface #(
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
   parameter logic [31:0] ADDR_SIZE   = 32'h0000_1000
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic        hresp,
   output logic [31:0] hrdata,
   output logic        valid_out,
   output logic [31:0] addr_out,
   output logic [31:0] dout,
   output logic        hwrite_out,
   input  logic [31:0] din
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RD_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   localparam logic [2:0] WS_LOAD =
      (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_t      state, next;
   logic [2:0]  cnt, cnt_next;
   logic [31:0] addr_reg;
   logic        write_reg;
   logic        accept;
   logic        take;
   logic        in_range;
   logic        size_err;
   logic        xfer_err;

   assign accept = hsel & hready & (htrans == 2'b10 || htrans == 2'b11);

   always_comb begin
      in_range = (haddr >= ADDR_BASE) && ((haddr - ADDR_BASE) < ADDR_SIZE);
      size_err = (hsize > 3'd2)
               | ((hsize == 3'd1) & haddr[0])
               | ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
      xfer_err = !in_range || size_err;
   end

   always_comb begin
      next       = state;
      cnt_next   = cnt;
      take       = 1'b0;
      hreadyout  = 1'b1;
      hresp      = 1'b0;
      hrdata     = 32'h0;
      valid_out  = 1'b0;
      addr_out   = 32'h0;
      dout       = 32'h0;
      hwrite_out = 1'b0;
      unique case (state)
         S_IDLE: take = 1'b1;
         S_WAIT: begin
            hreadyout = 1'b0;
            if (cnt == 3'd0) next = S_ACCESS;
            else cnt_next = cnt - 3'd1;
         end
         S_ACCESS: begin
            valid_out = 1'b1;
            addr_out  = addr_reg;
            if (write_reg) begin
               hwrite_out = 1'b1;
               dout       = hwdata;
               take       = 1'b1;
            end else begin
               hreadyout = 1'b0;
               next      = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            hrdata = din;
            take   = 1'b1;
         end
         S_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
            next      = S_ERR2;
         end
         S_ERR2: begin
            hresp = 1'b1;
            take  = 1'b1;
         end
         default: next = S_IDLE;
      endcase
      // Any state that completes its data phase may start the next transfer
      if (take) begin
         next = S_IDLE;
         if (accept) begin
            if (xfer_err) begin
               next = S_ERR1;
            end else if (WAIT_STATES > 0) begin
               next     = S_WAIT;
               cnt_next = WS_LOAD;
            end else begin
               next = S_ACCESS;
            end
         end
      end
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state     <= S_IDLE;
         cnt       <= 3'd0;
         addr_reg  <= 32'h0;
         write_reg <= 1'b0;
      end else begin
         state <= next;
         cnt   <= cnt_next;
         if (take && accept) begin
            addr_reg  <= haddr;
            write_reg <= hwrite;
         end
      end
   end

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Bench for ahb_slave_interface: WS=0 vector table plus WS=2
// pipelining and mid-transfer reset sequences.
module tb_ahb_slave_interface;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;

   logic        rdy0, resp0, v0, w0;
   logic [31:0] rdata0, a0, d0, din0;
   logic        rdy2, resp2, v2, w2;
   logic [31:0] rdata2, a2, d2, din2;

   int checks = 0;
   int errors = 0;
   int vcnt2 = 0;
   int base;

   always #5 clk = ~clk;

   ahb_slave_interface #(.WAIT_STATES(0)) dut0 (
      .hclk(clk), .hresetn(rst_n), .hsel(hsel), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
      .hready(rdy0), .hreadyout(rdy0), .hresp(resp0), .hrdata(rdata0),
      .valid_out(v0), .addr_out(a0), .dout(d0), .hwrite_out(w0),
      .din(din0)
   );

   ahb_slave_interface #(.WAIT_STATES(2)) dut2 (
      .hclk(clk), .hresetn(rst_n), .hsel(hsel), .haddr(haddr),
      .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
      .hready(rdy2), .hreadyout(rdy2), .hresp(resp2), .hrdata(rdata2),
      .valid_out(v2), .addr_out(a2), .dout(d2), .hwrite_out(w2),
      .din(din2)
   );

   // Backend model: registered read data derived from the request address
   always @(posedge clk) begin
      din0 <= a0 ^ 32'hA5A5_A5A5;
      din2 <= a2 ^ 32'hA5A5_A5A5;
      if (v2) vcnt2 <= vcnt2 + 1;
   end

   typedef struct {
      logic        hsel;
      logic [1:0]  htrans;
      logic        hwrite;
      logic [2:0]  hsize;
      logic [31:0] haddr;
      logic [31:0] hwdata;
      logic        rdy;
      logic        resp;
      logic        vld;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] dout;
      logic [31:0] rdata;
   } vec_t;

   vec_t tab[$];

   function automatic vec_t v(
      logic s, logic [1:0] t, logic w, logic [2:0] z,
      logic [31:0] a, logic [31:0] d,
      logic er, logic ep, logic ev, logic ew,
      logic [31:0] ea, logic [31:0] ed, logic [31:0] eq);
      vec_t r;
      r.hsel = s; r.htrans = t; r.hwrite = w; r.hsize = z;
      r.haddr = a; r.hwdata = d;
      r.rdy = er; r.resp = ep; r.vld = ev; r.wr = ew;
      r.addr = ea; r.dout = ed; r.rdata = eq;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   task automatic drv(logic s, logic [1:0] t, logic w, logic [2:0] z,
                      logic [31:0] a, logic [31:0] d);
      hsel = s; htrans = t; hwrite = w; hsize = z;
      haddr = a; hwdata = d;
   endtask

   task automatic chk_rst2(string tag);
      chk({tag, " rdy"}, 32'(rdy2), 32'd1);
      chk({tag, " resp"}, 32'(resp2), 32'd0);
      chk({tag, " rdata"}, rdata2, 32'h0);
      chk({tag, " vld"}, 32'(v2), 32'd0);
      chk({tag, " addr"}, a2, 32'h0);
      chk({tag, " dout"}, d2, 32'h0);
      chk({tag, " wr"}, 32'(w2), 32'd0);
   endtask

   initial begin
      tab.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,0,0));
      tab.push_back(v(1,2,1,2,'h10,0, 1,0,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,'hDEADBEEF,
                      1,0,1,1,'h10,'hDEADBEEF,0));
      tab.push_back(v(1,2,0,2,'h20,0, 1,0,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 0,0,1,0,'h20,0,0));
      tab.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,0,'hA5A5A585));
      tab.push_back(v(1,2,0,2,'h2000,0, 1,0,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0,0));
      tab.push_back(v(1,2,1,2,'h6,0, 1,1,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0,0));
      tab.push_back(v(1,1,0,0,0,0, 1,1,0,0,0,0,0));
      tab.push_back(v(1,0,0,0,0,0, 1,0,0,0,0,0,0));
      tab.push_back(v(1,2,0,1,'h101,0, 1,0,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0,0));
      tab.push_back(v(1,2,1,3,0,0, 1,1,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 1,1,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,0,0));
      tab.push_back(v(1,2,1,0,'h40,0, 1,0,0,0,0,0,0));
      tab.push_back(v(1,3,1,1,'h42,'h11111111,
                      1,0,1,1,'h40,'h11111111,0));
      tab.push_back(v(0,0,0,0,0,'h22222222,
                      1,0,1,1,'h42,'h22222222,0));
      tab.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,0,0));
      tab.push_back(v(1,2,0,0,'hFFF,0, 1,0,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 0,0,1,0,'hFFF,0,0));
      tab.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,0,'hA5A5AA5A));
      tab.push_back(v(1,2,0,0,'h1000,0, 1,0,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 0,1,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 1,1,0,0,0,0,0));
      tab.push_back(v(0,0,0,0,0,0, 1,0,0,0,0,0,0));

      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      chk("rst0 rdy", 32'(rdy0), 32'd1);
      chk("rst0 resp", 32'(resp0), 32'd0);
      chk("rst0 vld", 32'(v0), 32'd0);
      chk_rst2("rst2");
      rst_n = 1'b1;

      foreach (tab[i]) begin
         @(negedge clk);
         drv(tab[i].hsel, tab[i].htrans, tab[i].hwrite, tab[i].hsize,
             tab[i].haddr, tab[i].hwdata);
         #1;
         chk($sformatf("r%0d rdy", i), 32'(rdy0), 32'(tab[i].rdy));
         chk($sformatf("r%0d resp", i), 32'(resp0), 32'(tab[i].resp));
         chk($sformatf("r%0d vld", i), 32'(v0), 32'(tab[i].vld));
         chk($sformatf("r%0d wr", i), 32'(w0), 32'(tab[i].wr));
         chk($sformatf("r%0d addr", i), a0, tab[i].addr);
         chk($sformatf("r%0d dout", i), d0, tab[i].dout);
         chk($sformatf("r%0d rdata", i), rdata0, tab[i].rdata);
      end

      // WS=2: write then SEQ read back-to-back
      drv(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      drv(1, 2, 1, 2, 'h0, 0);
      #1;
      chk("t5 idle rdy", 32'(rdy2), 32'd1);
      base = vcnt2;
      @(negedge clk);
      drv(1, 3, 0, 2, 'h4, 'hCAFEF00D);
      #1;
      chk("t5 w1 rdy", 32'(rdy2), 32'd0);
      chk("t5 w1 vld", 32'(v2), 32'd0);
      @(negedge clk); #1;
      chk("t5 w2 rdy", 32'(rdy2), 32'd0);
      @(negedge clk); #1;
      chk("t5 wacc vld", 32'(v2), 32'd1);
      chk("t5 wacc wr", 32'(w2), 32'd1);
      chk("t5 wacc addr", a2, 32'h0);
      chk("t5 wacc dout", d2, 32'hCAFEF00D);
      chk("t5 wacc rdy", 32'(rdy2), 32'd1);
      @(negedge clk);
      drv(0, 0, 0, 0, 0, 0);
      #1;
      chk("t5 r1 rdy", 32'(rdy2), 32'd0);
      chk("t5 r1 dout", d2, 32'h0);
      @(negedge clk); #1;
      chk("t5 r2 rdy", 32'(rdy2), 32'd0);
      @(negedge clk); #1;
      chk("t5 racc vld", 32'(v2), 32'd1);
      chk("t5 racc wr", 32'(w2), 32'd0);
      chk("t5 racc addr", a2, 32'h4);
      chk("t5 racc rdy", 32'(rdy2), 32'd0);
      @(negedge clk); #1;
      chk("t5 rd rdy", 32'(rdy2), 32'd1);
      chk("t5 rd rdata", rdata2, 32'hA5A5A5A1);
      @(negedge clk); #1;
      chk("t5 after rdata", rdata2, 32'h0);
      chk("t5 vld count", 32'(vcnt2 - base), 32'd2);

      // WS=2: reset held two cycles in the middle of a wait phase
      @(negedge clk);
      drv(1, 2, 1, 2, 'h8, 0);
      @(negedge clk);
      drv(0, 0, 0, 0, 0, 0);
      #1;
      chk("t1 in wait", 32'(rdy2), 32'd0);
      base = vcnt2;
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk_rst2("t1 rst");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk_rst2("t1 post");
      chk("t1 no vld", 32'(vcnt2 - base), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
